// File: rtl/ex_md_pkg.sv
// rtl/ex_md_pkg.sv - shared M-extension encodings and ex_md FSM state type
package ex_md_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] INST_FUNCT7_M = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'd0;
  localparam logic [2:0] INST_MULH   = 3'd1;
  localparam logic [2:0] INST_MULHSU = 3'd2;
  localparam logic [2:0] INST_MULHU  = 3'd3;
  localparam logic [2:0] INST_DIV    = 3'd4;
  localparam logic [2:0] INST_DIVU   = 3'd5;
  localparam logic [2:0] INST_REM    = 3'd6;
  localparam logic [2:0] INST_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/ex_md_div.sv
// rtl/ex_md_div.sv - radix-2 restoring divider on magnitudes, one quotient bit per cycle
module ex_md_div
  import ex_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CW = $clog2(XLEN);

  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;

  logic [XLEN:0]   w_part;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // the borrow bit tells whether the divisor fits.
  assign w_part    = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_part - {1'b0, r_div};
  assign w_ge      = !w_diff[XLEN];
  assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_part[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

  // done flags the last iteration; the outputs carry that iteration's result
  assign o_done      = r_busy && (r_cnt == CW'(XLEN - 1));
  assign o_quotient  = w_quo_nxt;
  assign o_remainder = w_rem_nxt;

  // Iteration state: quotient bits replace dividend bits in r_quo as they shift out
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_div  <= i_divisor;
    end else if (r_busy) begin
      r_rem  <= w_rem_nxt;
      r_quo  <= w_quo_nxt;
      r_cnt  <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_md.sv
// rtl/ex_md.sv - M-extension execute unit; divider present only with EX_MD_DIV_EN
module ex_md
  import ex_md_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   op1_i,
  input  logic [XLEN-1:0]   op2_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              flush_i,
  output logic              hold_flag_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              rd_wen_o
);

  md_state_e         r_state;
  md_state_e         w_state_nxt;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_op1;
  logic [XLEN-1:0]   r_op2;
  logic [XLEN-1:0]   r_result;
  logic [REG_AW-1:0] r_rd;

  logic              w_accept;
  logic              w_wb;
  logic [XLEN-1:0]   w_start_res;
  logic [2*XLEN-1:0] w_mul_a;
  logic [2*XLEN-1:0] w_mul_b;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

  // A flush in the start cycle cancels the request before anything is captured
  assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;

  // Extending both operands to 2*XLEN makes one unsigned multiply serve all four signedness mixes
  assign w_mul_a   = {{XLEN{r_op1[XLEN-1] && (r_funct3 != INST_MULHU)}}, r_op1};
  assign w_mul_b   = {{XLEN{r_op2[XLEN-1] && ((r_funct3 == INST_MUL) || (r_funct3 == INST_MULH))}}, r_op2};
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_mul_res = (r_funct3 == INST_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef EX_MD_DIV_EN
  logic            w_in_signed;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic            w_div_start;
  logic            w_div_done;
  logic            w_q_neg;
  logic            w_r_neg;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_div_res;

  // DIV and REM have funct3[0] clear; REM/REMU have funct3[1] set
  assign w_in_signed = !funct3_i[0];
  assign w_div_zero  = (op2_i == '0);
  assign w_div_ovf   = w_in_signed && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
  assign w_special   = w_div_zero || w_div_ovf;
  assign w_abs1      = (w_in_signed && op1_i[XLEN-1]) ? -op1_i : op1_i;
  assign w_abs2      = (w_in_signed && op2_i[XLEN-1]) ? -op2_i : op2_i;
  assign w_div_start = w_accept && funct3_i[2] && !w_special;

  // Special-case results are known in the start cycle and skip the divider
  always_comb begin
    w_start_res = '0;
    if (w_div_zero)     w_start_res = funct3_i[1] ? op1_i : '1;
    else if (w_div_ovf) w_start_res = funct3_i[1] ? '0 : op1_i;
  end

  ex_md_div #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_start),
    .i_abort     (flush_i),
    .i_dividend  (w_abs1),
    .i_divisor   (w_abs2),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // Restore signs: quotient negative when operand signs differ, remainder follows the dividend
  assign w_q_neg   = !r_funct3[0] && (r_op1[XLEN-1] ^ r_op2[XLEN-1]);
  assign w_r_neg   = !r_funct3[0] && r_op1[XLEN-1];
  assign w_div_res = r_funct3[1] ? (w_r_neg ? -w_rem : w_rem) : (w_q_neg ? -w_quo : w_quo);
`else
  assign w_start_res = '0;
`endif

  // Writeback only in DONE, and a same-cycle flush suppresses it
  assign w_wb        = (r_state == S_DONE) && !flush_i;
  assign rd_wen_o    = w_wb && (r_rd != '0);
  assign rd_data_o   = w_wb ? r_result : '0;
  assign rd_addr_o   = w_wb ? r_rd : '0;
  assign hold_flag_o = ((r_state == S_IDLE) && start_i) || (r_state == S_MUL) || (r_state == S_DIV);

  // Next-state selection; flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (!funct3_i[2])    w_state_nxt = S_MUL;
`ifdef EX_MD_DIV_EN
          else if (!w_special) w_state_nxt = S_DIV;
`endif
          else                 w_state_nxt = S_DONE;
        end
      end
      S_MUL:  w_state_nxt = S_DONE;
`ifdef EX_MD_DIV_EN
      S_DIV:  if (w_div_done) w_state_nxt = S_DONE;
`endif
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture at start, then result latch on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3 <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_rd     <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_funct3 <= funct3_i;
        r_op1    <= op1_i;
        r_op2    <= op2_i;
        r_rd     <= rd_addr_i;
        r_result <= w_start_res;
      end else if (r_state == S_MUL) begin
        r_result <= w_mul_res;
      end
`ifdef EX_MD_DIV_EN
      else if ((r_state == S_DIV) && w_div_done) begin
        r_result <= w_div_res;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ex_md.sv
// tb/tb_ex_md.sv - scoreboard bench for ex_md against an arithmetic reference model
module tb_ex_md;
  import ex_md_pkg::*;

`ifdef EX_MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        hold_flag_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o;

  ex_md #(.XLEN(32), .REG_AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .funct3_i    (funct3_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .hold_flag_o (hold_flag_o),
    .rd_data_o   (rd_data_o),
    .rd_addr_o   (rd_addr_o),
    .rd_wen_o    (rd_wen_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        wen;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  bit   chk_en  = 1'b0;
  int   busy_lo = -1;
  int   busy_hi = -1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    case (f)
      INST_MUL:    p = sa * sbv;
      INST_MULH:   p = (sa * sbv) >> 32;
      INST_MULHSU: p = (sa * ub) >> 32;
      INST_MULHU:  p = (ua * ub) >> 32;
      default: begin
        if (!DIV_EN)               p = 64'd0;
        else if (b == 32'd0)       p = f[1] ? {32'd0, a} : 64'hFFFF_FFFF;
        else if (is_special(f, a, b)) p = f[1] ? 64'd0 : {32'd0, a};
        else if (!f[0])            p = f[1] ? (sa % sbv) : (sa / sbv);
        else                       p = f[1] ? (ua % ub) : (ua / ub);
      end
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2])                 return 2;
    if (!DIV_EN)               return 1;
    if (is_special(f, a, b))   return 1;
    return 33;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_inputs();
    funct3_i  = 3'($urandom);
    op1_i     = $urandom;
    op2_i     = $urandom;
    rd_addr_i = 5'($urandom);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int   lat;
    exp_t e;
    lat    = ref_lat(f, a, b);
    e.data = ref_result(f, a, b);
    e.addr = rd;
    e.wen  = (rd != 5'd0);
    e.at   = cyc + lat;
    sb.push_back(e);
    busy_lo = cyc;
    busy_hi = cyc + lat - 1;
    start_i = 1'b1; funct3_i = f; op1_i = a; op2_i = b; rd_addr_i = rd;
    for (int i = 1; i <= lat; i++) begin
      step();
      start_i = ($urandom_range(0, 3) == 0);
      junk_inputs();
    end
    step();
    start_i = 1'b0;
  endtask

  task automatic run_abort(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int k, input bit use_rst);
    int lat;
    lat = ref_lat(f, a, b);
    busy_lo = cyc;
    busy_hi = cyc + ((k < lat - 1) ? k : lat - 1);
    start_i = 1'b1; funct3_i = f; op1_i = a; op2_i = b; rd_addr_i = rd;
    if (k == 0) begin
      if (use_rst) rst = 1'b1; else flush_i = 1'b1;
    end
    for (int i = 1; i <= k; i++) begin
      step();
      start_i = 1'b0;
      if (use_rst) rst = (i == k); else flush_i = (i == k);
    end
    step();
    start_i = 1'b0; flush_i = 1'b0; rst = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: writeback cycles pop the scoreboard, all other cycles must be quiet
  always @(negedge clk) begin
    if (chk_en) begin
      if (sb.size() > 0 && sb[0].at == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_wen",  64'(rd_wen_o),  64'(e.wen));
        chk("wb_data", 64'(rd_data_o), 64'(e.data));
        chk("wb_addr", 64'(rd_addr_o), 64'(e.addr));
      end else begin
        chk("quiet_out", {27'd0, rd_wen_o, rd_addr_o, rd_data_o}, 64'd0);
      end
      chk("hold_flag", 64'(hold_flag_o), 64'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; op1_i = '0; op2_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    step(); step();

    run_op(INST_MUL,    32'd7,          -32'sd3,        5'd5);
    run_op(INST_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1);
    run_op(INST_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd2);
    run_op(INST_DIV,    -32'sd20,       32'd3,          5'd3);
    run_op(INST_REM,    -32'sd20,       32'd3,          5'd4);
    run_op(INST_DIVU,   32'd5,          32'd0,          5'd6);
    run_op(INST_REM,    32'd5,          32'd0,          5'd7);
    run_op(INST_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd8);
    run_op(INST_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd9);
    run_op(INST_REMU,   32'd100,        32'd7,          5'd10);
    run_op(INST_MUL,    32'd3,          32'd4,          5'd0);

    run_abort(DIV_EN ? INST_DIV : INST_MUL, 32'd100, 32'd7, 5'd11, DIV_EN ? 10 : 1, 1'b0);
    run_op(INST_MUL, 32'd123, 32'd456, 5'd12);
    run_abort(INST_MUL, 32'd5, 32'd6, 5'd13, 2, 1'b0);
    run_abort(INST_MULH, 32'd5, 32'd6, 5'd14, 0, 1'b0);
    run_abort(DIV_EN ? INST_DIVU : INST_MUL, 32'd1000, 32'd9, 5'd15, DIV_EN ? 5 : 1, 1'b1);
    run_op(INST_MULH, 32'h8000_0000, 32'h8000_0000, 5'd16);

    for (int n = 0; n < 60; n++) begin
      f = 3'($urandom);
      run_op(f, pick_operand(), pick_operand(), 5'($urandom));
    end

    repeat (3) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
